// File: rtl/queue_seq_mux_nch.sv
// N-channel round-robin queue steering: one active input channel feeds a 2-entry
// elastic buffer whose head is presented on the output lane matching its source channel.
module queue_seq_mux_nch #(
  parameter int N_CH         = 4,
  parameter int W_DATA       = 16,
  parameter int EOT_PER_TURN = 1,
  parameter int W_IDX        = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*W_DATA-1:0]   din_data,
  input  logic [N_CH-1:0]          din_valid,
  output logic [N_CH-1:0]          din_ready,
  output logic [W_DATA-1:0]        dout_data,
  output logic [N_CH-1:0]          dout_valid,
  input  logic [N_CH-1:0]          dout_ready,
  input  logic [W_IDX:0]           trig_data,
  input  logic                     trig_valid,
  output logic                     trig_ready,
  input  logic [N_CH-1:0]          ch_en,
  output logic [W_IDX-1:0]         active_ch
);

  logic [W_IDX-1:0]  active;
  logic [7:0]        eot_cnt;

  // Buffer entries keep their source channel as a one-hot lane mask; zero means empty.
  logic [N_CH-1:0]   hd_oh_p1, tl_oh_p1;
  logic [W_DATA-1:0] hd_data_p1, tl_data_p1;

  logic [N_CH-1:0]   act_oh;
  logic [W_DATA-1:0] in_data;
  logic              in_vld, full, push, pop, hd_vld, tl_vld;
  logic              hd_load_tl, hd_load_in, tl_load_in;
  logic              trig_hit;
  logic [W_IDX-1:0]  trig_ch, trig_tgt;

  // Next enabled channel after cur, wrapping; cur itself is the last candidate.
  function automatic logic [W_IDX-1:0] next_ch(input logic [W_IDX-1:0] cur,
                                               input logic [N_CH-1:0]  en);
    logic [W_IDX-1:0] res;
    int idx;
    res = cur;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(cur) + k) % N_CH;
      if (en[idx]) res = W_IDX'(idx);
    end
    return res;
  endfunction

  always_comb begin
    in_data = '0;
    in_vld  = 1'b0;
    act_oh  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (W_IDX'(i) == active) begin
        in_data   = din_data[i*W_DATA +: W_DATA];
        in_vld    = din_valid[i];
        act_oh[i] = 1'b1;
      end
    end
  end

  assign hd_vld = |hd_oh_p1;
  assign tl_vld = |tl_oh_p1;
  assign full   = hd_vld && tl_vld;
  assign push   = in_vld && !rst && !full;
  assign pop    = |(hd_oh_p1 & dout_ready);

  assign hd_load_tl = pop && tl_vld;
  assign hd_load_in = push && (pop ? !tl_vld : !hd_vld);
  assign tl_load_in = push && (pop ? tl_vld : hd_vld);

  assign trig_hit = trig_valid && trig_data[0];
  assign trig_ch  = trig_data[W_IDX:1];
  assign trig_tgt = (int'(trig_ch) >= N_CH) ? '0 : trig_ch;

  assign din_ready  = (rst || full) ? '0 : act_oh;
  assign dout_valid = hd_oh_p1;
  assign dout_data  = hd_data_p1;
  assign trig_ready = 1'b1;
  assign active_ch  = active;

  // Control state: active channel, eot counter and buffer occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= '0;
      eot_cnt  <= '0;
      hd_oh_p1 <= '0;
      tl_oh_p1 <= '0;
    end else begin
      if (trig_hit) begin
        active  <= trig_tgt;
        eot_cnt <= '0;
      end else if (push && in_data[W_DATA-1]) begin
        if (eot_cnt == 8'(EOT_PER_TURN - 1)) begin
          eot_cnt <= '0;
          active  <= next_ch(active, ch_en);
        end else begin
          eot_cnt <= eot_cnt + 8'd1;
        end
      end
      hd_oh_p1 <= hd_load_tl ? tl_oh_p1 : hd_load_in ? act_oh : (pop ? '0 : hd_oh_p1);
      tl_oh_p1 <= tl_load_in ? act_oh : (hd_load_tl ? '0 : tl_oh_p1);
    end
  end

  // Buffer payload follows the occupancy moves above; not reset.
  always_ff @(posedge clk) begin
    hd_data_p1 <= hd_load_tl ? tl_data_p1 : hd_load_in ? in_data : hd_data_p1;
    tl_data_p1 <= tl_load_in ? in_data : tl_data_p1;
  end

endmodule
